invert: RTL and testbench
=========================

# invert

Bit-serial two's-complement negator. A word enters on `i` one bit per clock, LSB first, and its two's complement leaves on `y` one bit per clock, registered, with a one-cycle latency. It sits in serial arithmetic datapaths between a shift-register source and a serial adder/sink. Word framing comes from an internal bit counter, so the block needs no framing strobe.

## Interface
Parameters:
- `WIDTH`, default 8: bits per serial word, legal values 0 and 2..64.
  - Non-zero: the negation state restarts automatically every `WIDTH` bits.
  - 0: framing disabled; the state clears only on reset.

Ports (positional order is i, r, clk, y):
- `clk`  input  1  rising-edge clock (single clock domain).
- `r`  input  1  reset, synchronous and active-low. The clock is `clk` and the reset is `r`, sampled only on the rising edge of `clk`.
- `i`  input  1  serial data in, LSB first, one bit per `clk` cycle.
- `y`  output  1  serial two's complement out, registered.

## Operation
- Internal state:
  - `seen`: 1 bit; a 1 has already passed in the current word.
  - `cnt`: bit index within the word, width clog2(WIDTH), minimum 1.
- On each rising `clk` edge with `r`=0:
  - `y` <= 0, `seen` <= 0, `cnt` <= 0.
  - `i` is ignored for that cycle.
- On each rising `clk` edge with `r`=1:
  - `y` <= `i` XOR `seen`.
  - If `cnt` == WIDTH-1 (WIDTH≠0): `seen` <= 0 and `cnt` <= 0, so the next bit starts a new word.
  - Otherwise: `seen` <= `seen` OR `i`, and `cnt` <= `cnt`+1 when WIDTH≠0.
- Effect: bits are copied up to and including the first 1. Every bit after that is inverted until the word ends.
- Boundary values:
  - All-zero word: output all zeros (−0 = 0).
  - 100…0 (most negative value): output equals input, the two's-complement overflow case. No flag is raised.
- When WIDTH=0, `cnt` is held at 0. `seen` is sticky until reset.

## Timing
- Latency is exactly 1 cycle. The `y` value after edge n corresponds to the `i` value sampled at edge n.
- Throughput is 1 bit per cycle with no stalls and no handshake.
- Reset value of `y` is 0, valid from the first edge at which `r`=0 is sampled.
- Reset asserted mid-word:
  - The partial word is abandoned.
  - The first edge with `r`=1 after the reset samples bit 0 of a new word.
- Asynchronous changes of `r` between edges have no effect.
- On the word-end edge (`cnt`==WIDTH-1), the output bit still uses the old `seen` value. The clear takes effect from the next bit.

## Structure
- Single module `invert` with no sub-modules. The design is a flip-flop, an XOR and a counter.
- Constants: counter width is computed locally as clog2 of WIDTH, with minimum 1. No shared package is needed.
- A shared `serial_pkg` may hold a default `SERIAL_WIDTH` constant if other serial blocks use one. Otherwise the block is self-contained.

## Test plan
- Reset:
  - Stimulus: `r`=0 for 2 edges with `i`=1.
  - Required: `y`=0 and the internal counter is 0. After release, the first sampled bit is bit 0.
- Basic negation:
  - Stimulus: WIDTH=4, `i` LSB-first 0,1,1,0 (value 6).
  - Required: `y` = 0,1,0,1 one cycle later (value 10 = −6 mod 16).
- Back-to-back words:
  - Stimulus: WIDTH=4, word 1 = 1,0,0,0 (1), then word 2 = 0,0,1,0 (4) immediately after.
  - Required: `y` = 1,1,1,1 (15), then 0,0,1,1 (12). Confirms `seen` clears at the word boundary.
- Zero and minimum values:
  - Stimulus: WIDTH=4, 0,0,0,0, then 0,0,0,1 (8).
  - Required: `y` = 0,0,0,0, then 0,0,0,1.
- Mid-word reset:
  - Stimulus: WIDTH=4, bits 1,1, then `r`=0 for 1 edge, then 0,1,0,0.
  - Required: `y` = 0 during reset, then 0,1,1,1 (14 = −2).
- Unframed mode:
  - Stimulus: WIDTH=0, stream 0,1,0,0,1,1.
  - Required: `y` = 0,1,1,1,0,0.

Source files
------------

// File: rtl/invert_pkg.sv
// Shared constants for serial datapath blocks.
// Default word width and counter sizing helper.
package invert_pkg;

  localparam int SERIAL_WIDTH = 8;

  // Bit-index counter width; never below 1 so the
  // counter stays a legal vector when framing is off.
  function automatic int cnt_width(input int w);
    int c;
    c = (w > 1) ? $clog2(w) : 1;
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/invert.sv
// Bit-serial two's-complement negator, LSB first.
// Ports: i serial in, r sync active-low reset, clk, y serial out.
module invert
  import invert_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH
) (
  input  logic i,
  input  logic r,
  input  logic clk,
  output logic y
);

  localparam int CW = cnt_width(WIDTH);
  localparam bit FRAMED = (WIDTH != 0);
  localparam logic [CW-1:0] LAST =
    CW'(FRAMED ? WIDTH - 1 : 0);

  logic          seen;
  logic [CW-1:0] cnt;
  logic          word_end;

  assign word_end = FRAMED && (cnt == LAST);

  // Copy bits through the first 1, invert after it.
  // The word-end bit still uses the old seen value.
  always_ff @(posedge clk) begin
    if (!r) begin
      y    <= 1'b0;
      seen <= 1'b0;
      cnt  <= '0;
    end else begin
      y <= i ^ seen;
      if (word_end) begin
        seen <= 1'b0;
        cnt  <= '0;
      end else begin
        seen <= seen | i;
        if (FRAMED)
          cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_invert.sv
// Directed self-checking bench for invert.
// Covers WIDTH=4 framed and WIDTH=0 unframed.
module tb_invert;

  logic clk;
  logic r;
  logic i;
  logic y4;
  logic y0;

  int n_cmp;
  int n_bad;

  invert #(.WIDTH(4)) dut4 (
    .i  (i),
    .r  (r),
    .clk(clk),
    .y  (y4)
  );

  invert #(.WIDTH(0)) dut0 (
    .i  (i),
    .r  (r),
    .clk(clk),
    .y  (y0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(input logic rr, input logic ii);
    r = rr;
    i = ii;
    @(posedge clk);
    #1;
  endtask

  // Apply n bits LSB first; check the chosen DUT
  // output after each edge against yb.
  task automatic word(
    input string tag,
    input bit sel0,
    input int n,
    input logic [7:0] ib,
    input logic [7:0] yb
  );
    for (int k = 0; k < n; k++) begin
      step(1'b1, ib[k]);
      check($sformatf("%s[%0d]", tag, k),
            {7'b0, sel0 ? y0 : y4}, {7'b0, yb[k]});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    r = 1'b0;
    i = 1'b1;
    #2;

    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("rst_y4", {7'b0, y4}, 8'h00);
    check("rst_y0", {7'b0, y0}, 8'h00);
    check("rst_cnt", {6'b0, dut4.cnt}, 8'h00);
    check("rst_seen", {7'b0, dut4.seen}, 8'h00);

    // 6 -> 10
    word("neg6", 1'b0, 4, 8'b0110, 8'b1010);
    // 1 -> 15, then 4 -> 12
    word("b2b1", 1'b0, 4, 8'b0001, 8'b1111);
    word("b2b4", 1'b0, 4, 8'b0100, 8'b1100);
    // -0 = 0, most negative maps to itself
    word("zero", 1'b0, 4, 8'b0000, 8'b0000);
    word("min8", 1'b0, 4, 8'b1000, 8'b1000);

    // Mid-word reset abandons the partial word
    word("part", 1'b0, 2, 8'b11, 8'b01);
    step(1'b0, 1'b1);
    check("mid_rst_y", {7'b0, y4}, 8'h00);
    check("mid_rst_cnt", {6'b0, dut4.cnt}, 8'h00);
    word("after", 1'b0, 4, 8'b0010, 8'b1110);
    // 15 -> 1, confirms framing realigned
    word("f15", 1'b0, 4, 8'b1111, 8'b0001);

    // Unframed: seen sticky across 4-bit span
    step(1'b0, 1'b0);
    check("rst0_y", {7'b0, y0}, 8'h00);
    word("unfr", 1'b1, 6, 8'b110010, 8'b001110);
    word("stick", 1'b1, 2, 8'b01, 8'b10);
    check("cnt0", {6'b0, dut0.cnt}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
